div_seq_ctrl: RTL and testbench

- Multi-cycle controller that sequences the combinational 2-bit-per-pass restoring division stage (div_4bits) into a complete 64-bit integer divider for the scalar pipeline's DIV/DIVU/REM/REMU and W variants.
- Handles the request/response handshake, operand sign conditioning, and iteration counting.
- Resolves divide-by-zero and signed overflow per the RISC-V spec, and corrects the result sign.
- Sits between the execute-stage issue logic and writeback.

---
 rtl/div_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequential 64-bit integer divider: drives a chain of 2-bit restoring stages
// through an IDLE/PREP/ITER/FIX/DONE handshake controller (DIV/DIVU/REM/REMU + W).

module div_4bits #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dq_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dq_o
);
    logic [XLEN:0] trial;

    // dq holds the dividend shifting out at the top and quotient bits entering at the bottom
    always_comb begin
        rem_o = rem_i;
        dq_o  = dq_i;
        trial = '0;
        for (int i = 0; i < 2; i++) begin
            trial = {rem_o, dq_o[XLEN-1]};
            dq_o  = {dq_o[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_i}) begin
                trial   = trial - {1'b0, dvs_i};
                dq_o[0] = 1'b1;
            end
            rem_o = trial[XLEN-1:0];
        end
    end
endmodule

module div_seq_ctrl #(
    parameter int XLEN       = 64,
    parameter int NUM_STAGES = 1,
    parameter int TAG_W      = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic             word_i,
    input  logic [XLEN-1:0]  dividend_i,
    input  logic [XLEN-1:0]  divisor_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);
    localparam int ITERS = 32 / NUM_STAGES;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t state, nxt;

    logic [1:0]      op_q;
    logic            word_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, dq_q, dvs_q;
    logic            neg_q, neg_r;
    logic [CNT_W-1:0] cnt;

    logic [NUM_STAGES:0][XLEN-1:0] rem_ch, dq_ch;

    assign rem_ch[0] = rem_q;
    assign dq_ch[0]  = dq_q;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        div_4bits #(.XLEN(XLEN)) u_stage (
            .rem_i (rem_ch[g]),
            .dq_i  (dq_ch[g]),
            .dvs_i (dvs_q),
            .rem_o (rem_ch[g+1]),
            .dq_o  (dq_ch[g+1])
        );
    end

    // Operand conditioning, evaluated from the latched request during PREP
    logic            sgn, sa, sb, div_zero, ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, spec_sel, spec_res;

    always_comb begin
        sgn      = op_q[0];
        a_ext    = a_q;
        b_ext    = b_q;
        if (word_q) begin
            a_ext = sgn ? {{32{a_q[31]}}, a_q[31:0]} : {32'b0, a_q[31:0]};
            b_ext = sgn ? {{32{b_q[31]}}, b_q[31:0]} : {32'b0, b_q[31:0]};
        end
        sa       = sgn & a_ext[XLEN-1];
        sb       = sgn & b_ext[XLEN-1];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        min_neg  = word_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = (b_ext == '0);
        ovf      = sgn & (a_ext == min_neg) & (b_ext == '1);
        special  = div_zero | ovf;
        // quotient: all ones on /0, dividend on overflow; remainder: dividend on /0, zero on overflow
        if (op_q[1])
            spec_sel = div_zero ? a_ext : '0;
        else
            spec_sel = div_zero ? '1 : a_ext;
        spec_res = word_q ? {{32{spec_sel[31]}}, spec_sel[31:0]} : spec_sel;
    end

    logic            fix_neg;
    logic [XLEN-1:0] fix_sel, fix_val, fix_res;

    always_comb begin
        fix_sel = op_q[1] ? rem_q : dq_q;
        fix_neg = op_q[0] & (op_q[1] ? neg_r : neg_q);
        fix_val = fix_neg ? -fix_sel : fix_sel;
        fix_res = word_q ? {{32{fix_val[31]}}, fix_val[31:0]} : fix_val;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt          = state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        busy_o       = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) nxt = PREP;
            end
            PREP: nxt = special ? DONE : ITER;
            ITER: if (cnt == '0) nxt = FIX;
            FIX:  nxt = DONE;
            DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (kill_i) nxt = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            word_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (!kill_i) begin
            case (state)
                IDLE: if (req_valid_i) begin
                    op_q   <= op_i;
                    word_q <= word_i;
                    a_q    <= dividend_i;
                    b_q    <= divisor_i;
                    tag_o  <= tag_i;
                end
                PREP: begin
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    if (special) begin
                        result_o <= spec_res;
                    end else begin
                        rem_q <= '0;
                        dq_q  <= a_mag;
                        dvs_q <= b_mag;
                        cnt   <= CNT_W'(ITERS - 1);
                    end
                end
                ITER: begin
                    rem_q <= rem_ch[NUM_STAGES];
                    dq_q  <= dq_ch[NUM_STAGES];
                    cnt   <= cnt - 1'b1;
                end
                FIX: result_o <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: results, latency, backpressure, kill and reset.

module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  op = 2'b00;
    logic        word = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic [5:0]  tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] result;
    logic [5:0]  tag_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .kill_i       (kill),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_i         (op),
        .word_i       (word),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .tag_i        (tag),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_o     (result),
        .tag_o        (tag_out),
        .busy_o       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present a request on a negedge; it is accepted on the following posedge.
    task automatic start(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] t);
        @(negedge clk);
        op = o; word = w; dividend = a; divisor = b; tag = t;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count cycles from presenting the request until resp_valid is seen.
    task automatic run_op(input string name, input logic [1:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [5:0] t,
                          input logic [63:0] exp, input int exp_lat);
        int n;
        start(o, w, a, b, t);
        n = 1;
        while (!resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk({name, "_res"}, result, exp);
        chk({name, "_tag"}, 64'(tag_out), 64'(t));
    endtask

    task automatic drain();
        @(posedge clk); #1;
        chk("drain_idle", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int seen;
        logic [63:0] held;

        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("divu",  2'b00, 1'b0, 64'd100, 64'd7, 6'd5, 64'd14, 35); drain();
        run_op("remu",  2'b10, 1'b0, 64'd100, 64'd7, 6'd6, 64'd2, 35); drain();
        run_op("div_neg", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd7,
               64'hFFFF_FFFF_FFFF_FFFD, 35); drain();
        run_op("rem_neg", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd8,
               64'hFFFF_FFFF_FFFF_FFFF, 35); drain();
        run_op("rem_negb", 2'b11, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 6'd9, 64'd1, 35); drain();
        run_op("divu_z", 2'b00, 1'b0, 64'h1234, 64'd0, 6'd10, 64'hFFFF_FFFF_FFFF_FFFF, 2); drain();
        run_op("remu_z", 2'b10, 1'b0, 64'h1234, 64'd0, 6'd11, 64'h1234, 2); drain();
        run_op("div_ovf", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd12,
               64'h8000_0000_0000_0000, 2); drain();
        run_op("rem_ovf", 2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd13,
               64'd0, 2); drain();
        run_op("divw_ovf", 2'b01, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd14,
               64'hFFFF_FFFF_8000_0000, 2); drain();
        run_op("remuw", 2'b10, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 6'd15, 64'hF, 35); drain();
        run_op("divuw_sx", 2'b00, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 6'd16,
               64'hFFFF_FFFF_FFFF_FFFF, 35); drain();

        // Backpressure: response must hold while writeback stalls.
        resp_ready = 1'b0;
        run_op("hold", 2'b00, 1'b0, 64'd1000, 64'd10, 6'd33, 64'd100, 35);
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_res", result, held);
            chk("hold_tag", 64'(tag_out), 64'd33);
            chk("hold_rdy", 64'(req_ready), 64'd0);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_rel_rdy", 64'(req_ready), 64'd1);
        chk("hold_rel_vld", 64'(resp_valid), 64'd0);

        // Kill mid-iteration: no response may ever appear.
        start(2'b00, 1'b0, 64'd500, 64'd3, 6'd20);
        repeat (10) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", 64'(busy), 64'd0);
        chk("kill_rdy", 64'(req_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("kill_noresp", 64'(seen), 64'd0);
        run_op("post_kill", 2'b00, 1'b0, 64'd9, 64'd3, 6'd21, 64'd3, 35); drain();

        // Reset mid-iteration: outputs return to reset values without a clock.
        start(2'b00, 1'b0, 64'd77, 64'd5, 6'd22);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("mrst_rdy", 64'(req_ready), 64'd1);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_vld", 64'(resp_valid), 64'd0);
        chk("mrst_res", result, 64'd0);
        chk("mrst_tag", 64'(tag_out), 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op("post_rst", 2'b01, 1'b0, 64'd77, 64'hFFFF_FFFF_FFFF_FFFB, 6'd23,
               64'hFFFF_FFFF_FFFF_FFF1, 35); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
